// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the CPU bus arbiter: arbiter state encoding, requester
// port identifiers, the abort read value and the tie-break helper.
package cpu_bus_arbiter_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Requester port identifiers.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_sel_t;

    // Read data returned to a requester whose transfer was aborted.
    localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

    // Choose the winning port among the active requests. On a tie the port
    // that was not served last wins. With no request the result is unused.
    function automatic port_sel_t pick_port(
        input logic      i_req,
        input logic      d_req,
        input port_sel_t last
    );
        port_sel_t sel;
        sel = PORT_I;
        if (i_req && d_req) begin
            sel = (last == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            sel = PORT_D;
        end else begin
            sel = PORT_I;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Two-port (instruction / data) arbiter onto a single request/ready bus.
// One transfer at a time; fair tie-break by last-served port; a bounded
// wait counter aborts a transfer the bus never acknowledges.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        i_clock,
    input  logic        i_reset,
    // Instruction port
    input  logic        i_i_rw,
    input  logic        i_i_request,
    output logic        o_i_ready,
    input  logic [31:0] i_i_address,
    output logic [31:0] o_i_rdata,
    input  logic [31:0] i_i_wdata,
    // Data port
    input  logic        i_d_rw,
    input  logic        i_d_request,
    output logic        o_d_ready,
    input  logic [31:0] i_d_address,
    output logic [31:0] o_d_rdata,
    input  logic [31:0] i_d_wdata,
    // Shared bus
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    // Timeout indication
    output logic        o_fault
);

    // Counter just wide enough to reach TIMEOUT, so it can never wrap.
    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_t        state_r;
    port_sel_t         last_grant_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    port_sel_t         winner_s;
    logic              timeout_s;
    logic              finish_s;
    logic [31:0]       done_rdata_s;

    // Next winner, timeout detection and the data handed back on completion.
    always_comb begin
        winner_s     = pick_port(i_i_request, i_d_request, last_grant_r);
        timeout_s    = 1'b0;
        done_rdata_s = ABORT_RDATA;
        if (wait_cnt_r == TIMEOUT_CNT) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        // A bus acknowledge in the timeout cycle still counts as a normal completion.
        if (i_bus_ready) begin
            done_rdata_s = i_bus_rdata;
        end else begin
            done_rdata_s = ABORT_RDATA;
        end
        finish_s = i_bus_ready | timeout_s;
    end

    // Arbiter FSM with all requester and bus outputs registered.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= PORT_I;
            wait_cnt_r    <= '0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= 32'h0000_0000;
            o_bus_wdata   <= 32'h0000_0000;
            o_i_ready     <= 1'b0;
            o_d_ready     <= 1'b0;
            o_i_rdata     <= 32'h0000_0000;
            o_d_rdata     <= 32'h0000_0000;
            o_fault       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_i_request || i_d_request) begin
                        // Bus fields are latched here and held for the whole transfer.
                        wait_cnt_r    <= '0;
                        o_bus_request <= 1'b1;
                        if (winner_s == PORT_D) begin
                            state_r       <= ST_GRANT_D;
                            o_bus_rw      <= i_d_rw;
                            o_bus_address <= i_d_address;
                            o_bus_wdata   <= i_d_wdata;
                        end else begin
                            state_r       <= ST_GRANT_I;
                            o_bus_rw      <= i_i_rw;
                            o_bus_address <= i_i_address;
                            o_bus_wdata   <= i_i_wdata;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_GRANT_I, ST_GRANT_D: begin
                    if (finish_s) begin
                        o_bus_request <= 1'b0;
                        o_fault       <= ~i_bus_ready;
                        state_r       <= ST_RELEASE;
                        if (state_r == ST_GRANT_I) begin
                            o_i_ready    <= 1'b1;
                            o_i_rdata    <= done_rdata_s;
                            last_grant_r <= PORT_I;
                        end else begin
                            o_d_ready    <= 1'b1;
                            o_d_rdata    <= done_rdata_s;
                            last_grant_r <= PORT_D;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    // One dead cycle lets the served requester drop its request.
                    o_i_ready <= 1'b0;
                    o_d_ready <= 1'b0;
                    o_fault   <= 1'b0;
                    state_r   <= ST_IDLE;
                end

                default: begin
                    state_r       <= ST_IDLE;
                    o_bus_request <= 1'b0;
                    o_i_ready     <= 1'b0;
                    o_d_ready     <= 1'b0;
                    o_fault       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: a transaction-level model predicts
// every output each cycle, plus directed scenarios with literal expectations.
module tb_cpu_bus_arbiter;

    localparam int TO = 8;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_i_rw, i_i_request, o_i_ready;
    logic [31:0] i_i_address, o_i_rdata, i_i_wdata;
    logic        i_d_rw, i_d_request, o_d_ready;
    logic [31:0] i_d_address, o_d_rdata, i_d_wdata;
    logic        o_bus_rw, o_bus_request, i_bus_ready;
    logic [31:0] o_bus_address, i_bus_rdata, o_bus_wdata;
    logic        o_fault;

    always #5 i_clock = ~i_clock;

    cpu_bus_arbiter #(.TIMEOUT(TO)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_i_rw       (i_i_rw),
        .i_i_request  (i_i_request),
        .o_i_ready    (o_i_ready),
        .i_i_address  (i_i_address),
        .o_i_rdata    (o_i_rdata),
        .i_i_wdata    (i_i_wdata),
        .i_d_rw       (i_d_rw),
        .i_d_request  (i_d_request),
        .o_d_ready    (o_d_ready),
        .i_d_address  (i_d_address),
        .o_d_rdata    (o_d_rdata),
        .i_d_wdata    (i_d_wdata),
        .o_bus_rw     (o_bus_rw),
        .o_bus_request(o_bus_request),
        .i_bus_ready  (i_bus_ready),
        .o_bus_address(o_bus_address),
        .i_bus_rdata  (i_bus_rdata),
        .o_bus_wdata  (o_bus_wdata),
        .o_fault      (o_fault)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // owner: 0 = bus free, 1 = I transfer in flight, 2 = D transfer in flight
    int          m_owner = 0;
    int          m_wait  = 0;
    int          m_last  = 1;
    bit          m_cool  = 1'b0;
    bit          m_valid = 1'b0;
    logic        e_bus_req, e_bus_rw, e_i_ready, e_d_ready, e_fault;
    logic [31:0] e_bus_addr, e_bus_wdata, e_i_rdata, e_d_rdata;

    function automatic int pick(input logic ir, input logic dr, input int last);
        if (ir && dr) return (last == 1) ? 2 : 1;
        else if (ir) return 1;
        else if (dr) return 2;
        else return 0;
    endfunction

    // Advance the model on each rising edge from the inputs the DUT sees.
    always @(posedge i_clock) begin
        if (!i_reset) begin
            m_valid <= 1'b1; m_owner <= 0; m_wait <= 0; m_last <= 1; m_cool <= 1'b0;
            e_bus_req <= 1'b0; e_bus_rw <= 1'b0; e_bus_addr <= 32'h0; e_bus_wdata <= 32'h0;
            e_i_ready <= 1'b0; e_d_ready <= 1'b0; e_i_rdata <= 32'h0; e_d_rdata <= 32'h0;
            e_fault <= 1'b0;
        end else if (m_cool) begin
            m_cool <= 1'b0; e_i_ready <= 1'b0; e_d_ready <= 1'b0; e_fault <= 1'b0;
        end else if (m_owner != 0) begin
            if (i_bus_ready || m_wait == TO) begin
                e_bus_req <= 1'b0;
                e_fault   <= !i_bus_ready;
                if (m_owner == 1) begin
                    e_i_ready <= 1'b1;
                    e_i_rdata <= i_bus_ready ? i_bus_rdata : 32'hFFFF_FFFF;
                end else begin
                    e_d_ready <= 1'b1;
                    e_d_rdata <= i_bus_ready ? i_bus_rdata : 32'hFFFF_FFFF;
                end
                m_last  <= m_owner;
                m_owner <= 0;
                m_cool  <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (pick(i_i_request, i_d_request, m_last) == 1) begin
            m_owner <= 1; m_wait <= 0; e_bus_req <= 1'b1;
            e_bus_rw <= i_i_rw; e_bus_addr <= i_i_address; e_bus_wdata <= i_i_wdata;
        end else if (pick(i_i_request, i_d_request, m_last) == 2) begin
            m_owner <= 2; m_wait <= 0; e_bus_req <= 1'b1;
            e_bus_rw <= i_d_rw; e_bus_addr <= i_d_address; e_bus_wdata <= i_d_wdata;
        end
    end

    // Compare every DUT output with the model mid-cycle.
    always @(negedge i_clock) begin
        if (m_valid) begin
            check("bus_request", 32'(o_bus_request), 32'(e_bus_req));
            check("bus_rw",      32'(o_bus_rw),      32'(e_bus_rw));
            check("bus_address", o_bus_address,      e_bus_addr);
            check("bus_wdata",   o_bus_wdata,        e_bus_wdata);
            check("i_ready",     32'(o_i_ready),     32'(e_i_ready));
            check("d_ready",     32'(o_d_ready),     32'(e_d_ready));
            check("i_rdata",     o_i_rdata,          e_i_rdata);
            check("d_rdata",     o_d_rdata,          e_d_rdata);
            check("fault",       32'(o_fault),       32'(e_fault));
        end
    end

    // ---------------- stimulus helpers ----------------
    int          bus_delay = 1000;
    int          bus_cnt   = 0;
    logic [31:0] bus_data  = 32'h0;
    bit          i_auto = 1'b0, d_auto = 1'b0, i_drop = 1'b0, d_drop = 1'b0;
    bit          track_wr = 1'b0;
    int          wr_bad, ni_rdy, nd_rdy, nfault, nbusreq, step_no, i_rdy_step;
    logic        prev_bus_req = 1'b0;
    logic [31:0] grant_log[$];

    function automatic logic [31:0] log_at(input int k);
        if (k < grant_log.size()) return grant_log[k];
        else return 32'hxxxx_xxxx;
    endfunction

    task automatic clr();
        ni_rdy = 0; nd_rdy = 0; nfault = 0; nbusreq = 0; wr_bad = 0;
        step_no = 0; i_rdy_step = -1;
        grant_log.delete();
    endtask

    // One cycle: observe outputs, then behave as requesters and bus slave.
    task automatic step();
        @(negedge i_clock);
        step_no++;
        if (o_i_ready) begin
            ni_rdy++;
            if (i_rdy_step < 0) i_rdy_step = step_no;
        end
        if (o_d_ready) nd_rdy++;
        if (o_fault) nfault++;
        if (o_bus_request) begin
            nbusreq++;
            if (!prev_bus_req) grant_log.push_back(o_bus_address);
            if (track_wr && (o_bus_rw !== 1'b1 || o_bus_wdata !== 32'h1234_5678)) wr_bad++;
        end
        prev_bus_req = o_bus_request;
        if (o_i_ready) begin
            i_i_request = 1'b0; i_drop = 1'b1;
        end else if (i_drop) begin
            if (i_auto) i_i_request = 1'b1;
            i_drop = 1'b0;
        end
        if (o_d_ready) begin
            i_d_request = 1'b0; d_drop = 1'b1;
        end else if (d_drop) begin
            if (d_auto) i_d_request = 1'b1;
            d_drop = 1'b0;
        end
        if (i_bus_ready) begin
            i_bus_ready = 1'b0;
        end else if (o_bus_request) begin
            if (bus_cnt == bus_delay) begin
                i_bus_ready = 1'b1;
                i_bus_rdata = bus_data;
            end
            bus_cnt++;
        end else begin
            bus_cnt = 0;
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0; i_i_request = 1'b0; i_d_request = 1'b0; i_bus_ready = 1'b0;
        repeat (3) step();
        i_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b0;
        i_i_rw = 1'b0; i_i_request = 1'b0; i_i_address = 32'h0; i_i_wdata = 32'h0;
        i_d_rw = 1'b0; i_d_request = 1'b0; i_d_address = 32'h0; i_d_wdata = 32'h0;
        i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
        clr();
        do_reset();

        // Reset values
        check("rst_bus_request", 32'(o_bus_request), 32'h0);
        check("rst_bus_address", o_bus_address, 32'h0);
        check("rst_i_rdata",     o_i_rdata,     32'h0);
        check("rst_d_ready",     32'(o_d_ready), 32'h0);

        // I read at 0x1000, bus acknowledges after two wait cycles
        clr();
        i_i_address = 32'h0000_1000; i_i_rw = 1'b0;
        bus_delay = 2; bus_data = 32'hDEAD_BEEF;
        i_i_request = 1'b1;
        repeat (10) step();
        check("t1_i_ready_pulses", 32'(ni_rdy), 32'd1);
        check("t1_d_ready_pulses", 32'(nd_rdy), 32'd0);
        check("t1_i_rdata",        o_i_rdata,   32'hDEAD_BEEF);
        check("t1_ready_step",     32'(i_rdy_step), 32'd4);
        check("t1_bus_req_cycles", 32'(nbusreq), 32'd3);

        // Zero-wait bus: request-to-ready spans three cycles
        clr();
        i_i_address = 32'h0000_1004; bus_delay = 0; bus_data = 32'h1111_2222;
        i_i_request = 1'b1;
        repeat (6) step();
        check("t1b_ready_step", 32'(i_rdy_step), 32'd2);
        check("t1b_i_rdata",    o_i_rdata,       32'h1111_2222);

        // Simultaneous requests after reset: D first, then I
        do_reset();
        clr();
        i_i_address = 32'h0000_3000; i_d_address = 32'h0000_4000;
        bus_delay = 0; bus_data = 32'h3333_4444;
        i_i_request = 1'b1; i_d_request = 1'b1;
        repeat (12) step();
        check("t2_grant_count", 32'(grant_log.size()), 32'd2);
        check("t2_first_addr",  log_at(0), 32'h0000_4000);
        check("t2_second_addr", log_at(1), 32'h0000_3000);

        // Both requesters keep re-requesting: grants alternate D, I, D, I ...
        clr();
        i_d_address = 32'h0000_5000; i_i_address = 32'h0000_6000;
        bus_data = 32'h5555_6666;
        i_auto = 1'b1; d_auto = 1'b1;
        i_i_request = 1'b1; i_d_request = 1'b1;
        for (int k = 0; k < 200 && grant_log.size() < 6; k++) step();
        i_auto = 1'b0; d_auto = 1'b0;
        repeat (12) step();
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_grant%0d", k), log_at(k),
                  (k % 2 == 0) ? 32'h0000_5000 : 32'h0000_6000);

        // Bus never acknowledges: abort after TIMEOUT+1 request cycles
        clr();
        i_d_address = 32'h0000_7000; i_d_rw = 1'b0; bus_delay = 1000;
        i_d_request = 1'b1;
        repeat (16) step();
        check("t4_bus_req_cycles", 32'(nbusreq), 32'd9);
        check("t4_fault_pulses",   32'(nfault),  32'd1);
        check("t4_d_ready_pulses", 32'(nd_rdy),  32'd1);
        check("t4_d_rdata",        o_d_rdata,    32'hFFFF_FFFF);

        // Following request is served normally
        clr();
        i_d_address = 32'h0000_7100; bus_delay = 1; bus_data = 32'hCAFE_F00D;
        i_d_request = 1'b1;
        repeat (8) step();
        check("t4b_d_ready_pulses", 32'(nd_rdy), 32'd1);
        check("t4b_fault_pulses",   32'(nfault), 32'd0);
        check("t4b_d_rdata",        o_d_rdata,   32'hCAFE_F00D);

        // Acknowledge in the very cycle the counter reaches TIMEOUT: no fault
        clr();
        bus_delay = 8; bus_data = 32'h0BAD_C0DE;
        i_d_request = 1'b1;
        repeat (14) step();
        check("t5_fault_pulses",   32'(nfault),  32'd0);
        check("t5_d_ready_pulses", 32'(nd_rdy),  32'd1);
        check("t5_d_rdata",        o_d_rdata,    32'h0BAD_C0DE);
        check("t5_bus_req_cycles", 32'(nbusreq), 32'd9);

        // D write: bus write fields stay stable even if the requester changes wdata
        clr();
        i_d_rw = 1'b1; i_d_address = 32'h0000_2000; i_d_wdata = 32'h1234_5678;
        bus_delay = 3; bus_data = 32'h0; track_wr = 1'b1;
        i_d_request = 1'b1;
        repeat (2) step();
        i_d_wdata = 32'hA5A5_A5A5;
        repeat (8) step();
        track_wr = 1'b0; i_d_rw = 1'b0;
        check("t6_write_fields_bad", 32'(wr_bad),  32'd0);
        check("t6_bus_req_cycles",   32'(nbusreq), 32'd4);
        check("t6_d_ready_pulses",   32'(nd_rdy),  32'd1);
        check("t6_addr",             log_at(0),    32'h0000_2000);

        // Reset during an I transfer, then a stray bus acknowledge
        clr();
        i_i_address = 32'h0000_8000; bus_delay = 1000;
        i_i_request = 1'b1;
        repeat (3) step();
        i_reset = 1'b0; i_i_request = 1'b0;
        step();
        check("t7_bus_request", 32'(o_bus_request), 32'h0);
        check("t7_bus_address", o_bus_address,      32'h0);
        check("t7_i_rdata",     o_i_rdata,          32'h0);
        i_reset = 1'b1;
        ni_rdy = 0; nfault = 0;
        i_bus_ready = 1'b1; i_bus_rdata = 32'h0000_0055;
        repeat (6) step();
        check("t7_i_ready_pulses", 32'(ni_rdy), 32'd0);
        check("t7_fault_pulses",   32'(nfault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: CPU_BusArbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, maximum bus wait cycles before abort.
REQ-002 i_clock  in  1  single clock; all logic on rising edge.
REQ-003 i_reset  in  1  synchronous, active-low reset.
REQ-004 Port I (instruction): i_i_rw in 1, i_i_request in 1, o_i_ready out 1, i_i_address in 32, o_i_rdata out 32, i_i_wdata in 32.
REQ-005 Port D (data): i_d_rw in 1, i_d_request in 1, o_d_ready out 1, i_d_address in 32, o_d_rdata out 32, i_d_wdata in 32.
REQ-006 Bus: o_bus_rw out 1, o_bus_request out 1, i_bus_ready in 1, o_bus_address out 32, i_bus_rdata in 32, o_bus_wdata out 32.
REQ-007 o_fault  out  1  one-cycle pulse when a transfer times out.

Function
REQ-008 Protocol on all ports: request held high until ready; ready is a one-cycle pulse; requester SHALL hold request low for at least one cycle after its ready.
REQ-009 States: IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-010 IDLE: sample both requests; if exactly one is high, grant it; if both are high, grant the port not served last (last_grant register); no request -> stay IDLE.
REQ-011 On grant at edge N, the registered o_bus_request=1 plus o_bus_rw/address/wdata copied from the winner are visible in cycle N+1.
REQ-012 Bus fields are captured once at grant and held stable until o_bus_request drops.
REQ-013 GRANT_x: on i_bus_ready=1 at edge M, o_bus_request=0, o_x_ready=1 and o_x_rdata=i_bus_rdata in cycle M+1; state -> RELEASE; last_grant=x.
REQ-014 Latency: requester-visible ready = bus ready + 1 cycle; minimum request-to-ready = 3 cycles with zero-wait bus.
REQ-015 RELEASE lasts exactly one cycle, ignores all requests, then -> IDLE; o_x_ready deasserts on leaving RELEASE.
REQ-016 Non-granted port's ready stays 0; its rdata holds last value.
REQ-017 o_rdata updates only on the granted port's completion; write transfers also update it (value don't-care).
REQ-018 Wait counter: 0 at grant; +1 each GRANT cycle without i_bus_ready; at count==TIMEOUT: o_bus_request=0, o_x_ready=1, o_x_rdata=32'hFFFF_FFFF, o_fault=1 for one cycle, -> RELEASE.
REQ-019 i_bus_ready in the same cycle the counter hits TIMEOUT: normal completion wins; no fault.
REQ-020 Counter width = $clog2(TIMEOUT+1); no wrap possible.
REQ-021 i_bus_ready while IDLE or RELEASE is ignored.
REQ-022 Requester dropping request mid-grant is illegal; arbiter completes the bus transfer regardless.

Reset
REQ-023 With i_reset=0 at a rising edge: state=IDLE, last_grant=I (D wins first tie), counter=0.
REQ-024 Reset values: o_bus_request, o_i_ready, o_d_ready, o_fault = 0; o_bus_rw = 0; o_bus_address, o_bus_wdata, o_i_rdata, o_d_rdata = 0.
REQ-025 Reset mid-transfer aborts immediately with no ready pulse; late bus ready after reset is ignored per REQ-021.

Structure
REQ-026 State enum and port-select enum (PORT_I, PORT_D) SHALL be in the shared CPU_Types package.
REQ-027 Arbiter is one module; no sub-module; all outputs registered.

Verification
REQ-028 I request only, address 0x1000, bus ready 2 cycles after o_bus_request, rdata 0xDEADBEEF -> o_i_ready one pulse, o_i_rdata=0xDEADBEEF, o_d_ready=0 throughout.
REQ-029 I and D requests same cycle after reset -> D granted first; I granted in the first IDLE after RELEASE; bus addresses in order D then I.
REQ-030 D request continuously re-raised per REQ-008 with I pending -> grants alternate D,I,D,I; no starvation.
REQ-031 TIMEOUT=8, bus never ready -> o_bus_request high exactly 9 cycles, o_fault one pulse, o_d_rdata=0xFFFFFFFF, next request served normally.
REQ-032 i_reset=0 asserted during GRANT_I -> next cycle all outputs at REQ-024 values; later i_bus_ready pulse produces no ready.
REQ-033 D write, address 0x2000, wdata 0x12345678 -> o_bus_rw=1, o_bus_wdata stable 0x12345678 until completion; o_d_ready one pulse.
